// File: rtl/lcd_hd44780_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_hd44780_rx_pkg : constants, FSM encoding and AC helpers shared    |
// |                      by the HD44780 responder.   Rev 1.0              |
// +----------------------------------------------------------------------+
package lcd_hd44780_rx_pkg;

   localparam int         DDRAM_DEPTH = 80;
   localparam int         LINE_LEN    = 40;
   localparam logic [6:0] LINE2_BASE  = 7'h40;
   localparam logic [7:0] CHAR_SPACE  = 8'h20;

   localparam logic [7:0] OP_CLEAR   = 8'h01;
   localparam logic [7:0] OP_HOME    = 8'h02;
   localparam logic [7:0] OP_ENTRY   = 8'h04;
   localparam logic [7:0] OP_DISPLAY = 8'h08;
   localparam logic [7:0] OP_SHIFT   = 8'h10;
   localparam logic [7:0] OP_FUNC    = 8'h20;
   localparam logic [7:0] OP_CGRAM   = 8'h40;
   localparam logic [7:0] OP_DDRAM   = 8'h80;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLEARING = 2'd1,
      BUSY     = 2'd2
   } state_t;

   function automatic logic [6:0] ddram_index(input logic [6:0] ac, input logic two);
      if (two)
         return ac[6] ? 7'(LINE_LEN) + {1'b0, ac[5:0]} : {1'b0, ac[5:0]};
      return ac;
   endfunction

   // Second line is not contiguous with the first in 2-line mode.
   function automatic logic [6:0] ac_next(input logic [6:0] ac, input logic inc, input logic two);
      if (two) begin
         if (inc) begin
            if (ac == 7'h27) return LINE2_BASE;
            if (ac == 7'h67) return 7'h00;
            return ac + 7'd1;
         end
         if (ac == LINE2_BASE) return 7'h27;
         if (ac == 7'h00)      return 7'h67;
         return ac - 7'd1;
      end
      if (inc)
         return (ac >= 7'(DDRAM_DEPTH - 1)) ? 7'h00 : ac + 7'd1;
      return (ac == 7'h00) ? 7'(DDRAM_DEPTH - 1) : ac - 7'd1;
   endfunction

   function automatic logic addr_valid(input logic [6:0] ac, input logic two);
      if (two)
         return ac[5:0] < 6'(LINE_LEN);
      return ac < 7'(DDRAM_DEPTH);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_hd44780_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_hd44780_rx_if : 4-bit HD44780 parallel bus (E/RS/RW/DB7..DB4).    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface lcd_hd44780_rx_if;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [3:0] lcd_db;

   modport master (output lcd_e, lcd_rs, lcd_rw, lcd_db);
   modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_db);
endinterface
`default_nettype wire

// File: rtl/lcd_hd44780_rx_ddram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_hd44780_rx_ddram : 80x8 display RAM, one write port, registered  |
// | reads on the write address and the mirror address.   Rev 1.0         |
// +----------------------------------------------------------------------+
module lcd_hd44780_rx_ddram
   import lcd_hd44780_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [6:0] waddr,
   input  logic [7:0] wdata,
   output logic [7:0] wr_rdata,
   input  logic [6:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [0:DDRAM_DEPTH-1];

   always_ff @(posedge clk) begin
      if (we && (waddr < 7'(DDRAM_DEPTH)))
         mem[waddr] <= wdata;
   end

   // Only the output registers are reset; the array itself is not.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_rdata <= 8'h00;
         rd_data  <= 8'h00;
      end else begin
         wr_rdata <= (waddr   < 7'(DDRAM_DEPTH)) ? mem[waddr]   : 8'h00;
         rd_data  <= (rd_addr < 7'(DDRAM_DEPTH)) ? mem[rd_addr] : 8'h00;
      end
   end

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_hd44780_rx : HD44780-compatible bus responder with DDRAM mirror. |
// | Define LCD_RX_SYNC_EN to add 2-flop input synchronizers.   Rev 1.0   |
// +----------------------------------------------------------------------+
module lcd_hd44780_rx
   import lcd_hd44780_rx_pkg::*;
#(
   parameter int BUSY_SHORT = 1000,
   parameter int BUSY_LONG  = 41000
) (
   input  logic            clk,
   input  logic            rst,
   lcd_hd44780_rx_if.slave bus,
   input  logic [6:0]      rd_addr,
   output logic [7:0]      rd_data,
   output logic            busy,
   output logic            four_bit,
   output logic            two_line,
   output logic            display_on,
   output logic            cursor_on,
   output logic            blink_on,
   output logic [6:0]      cursor_addr,
   output logic            cmd_valid,
   output logic [7:0]      cmd_byte,
   output logic            cmd_rs,
   output logic            proto_err
);

   localparam int BUSY_MAX = (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
   localparam int CNT_W    = $clog2(BUSY_MAX);
   localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(BUSY_SHORT - 1);
   localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(BUSY_LONG - 1);

   logic       src_e, src_rs, src_rw;
   logic [3:0] src_db;

`ifdef LCD_RX_SYNC_EN
   logic [1:0] sync_e, sync_rs, sync_rw;
   logic [3:0] sync_db0, sync_db1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_e   <= 2'b00;
         sync_rs  <= 2'b00;
         sync_rw  <= 2'b00;
         sync_db0 <= 4'h0;
         sync_db1 <= 4'h0;
      end else begin
         sync_e   <= {sync_e[0],  bus.lcd_e};
         sync_rs  <= {sync_rs[0], bus.lcd_rs};
         sync_rw  <= {sync_rw[0], bus.lcd_rw};
         sync_db0 <= bus.lcd_db;
         sync_db1 <= sync_db0;
      end
   end

   assign src_e  = sync_e[1];
   assign src_rs = sync_rs[1];
   assign src_rw = sync_rw[1];
   assign src_db = sync_db1;
`else
   assign src_e  = bus.lcd_e;
   assign src_rs = bus.lcd_rs;
   assign src_rw = bus.lcd_rw;
   assign src_db = bus.lcd_db;
`endif

   state_t           state;
   logic [6:0]       fill_idx;
   logic [CNT_W-1:0] cnt;
   logic             smp_e, smp_rs, smp_rw, e_prev;
   logic [3:0]       smp_db;
   logic             inc_dir, cgram_sel, phase_lo;
   logic [3:0]       hi_nib;

   logic       strobe, take, nib_ok, byte_done;
   logic [7:0] byte_val;
   logic [6:0] wr_idx;

   assign strobe    = e_prev & ~smp_e;
   assign take      = strobe & ~smp_rw;
   assign nib_ok    = take & ~busy;
   assign byte_done = nib_ok & (~four_bit | phase_lo);
   assign byte_val  = four_bit ? {hi_nib, smp_db} : {smp_db, 4'h0};
   assign wr_idx    = ddram_index(cursor_addr, two_line);

   logic [6:0] nxt_ac;
   logic       nxt_inc, nxt_disp, nxt_cur, nxt_blink, nxt_four, nxt_two, nxt_cg;
   logic       addr_err, start_clear, use_long;
   logic       mem_we;
   logic [6:0] mem_waddr;
   logic [7:0] mem_wdata;

   always_comb begin
      nxt_ac      = cursor_addr;
      nxt_inc     = inc_dir;
      nxt_disp    = display_on;
      nxt_cur     = cursor_on;
      nxt_blink   = blink_on;
      nxt_four    = four_bit;
      nxt_two     = two_line;
      nxt_cg      = cgram_sel;
      addr_err    = 1'b0;
      start_clear = 1'b0;
      use_long    = 1'b0;
      mem_we      = (state == CLEARING);
      mem_waddr   = fill_idx;
      mem_wdata   = CHAR_SPACE;
      if (byte_done) begin
         if (smp_rs) begin
            if (!cgram_sel) begin
               mem_we    = 1'b1;
               mem_waddr = wr_idx;
               mem_wdata = byte_val;
               nxt_ac    = ac_next(cursor_addr, inc_dir, two_line);
            end
         end else if (|(byte_val & OP_DDRAM)) begin
            nxt_cg = 1'b0;
            if (addr_valid(byte_val[6:0], two_line)) begin
               nxt_ac = byte_val[6:0];
            end else begin
               nxt_ac   = 7'h00;
               addr_err = 1'b1;
            end
         end else if (|(byte_val & OP_CGRAM)) begin
            nxt_cg = 1'b1;
         end else if (|(byte_val & OP_FUNC)) begin
            nxt_four = ~byte_val[4];
            nxt_two  = byte_val[3];
         end else if (|(byte_val & OP_SHIFT)) begin
            if (!byte_val[3])
               nxt_ac = ac_next(cursor_addr, byte_val[2], two_line);
         end else if (|(byte_val & OP_DISPLAY)) begin
            nxt_disp  = byte_val[2];
            nxt_cur   = byte_val[1];
            nxt_blink = byte_val[0];
         end else if (|(byte_val & OP_ENTRY)) begin
            nxt_inc = byte_val[1];
         end else if (|(byte_val & OP_HOME)) begin
            nxt_ac   = 7'h00;
            use_long = 1'b1;
         end else if (|(byte_val & OP_CLEAR)) begin
            nxt_ac      = 7'h00;
            nxt_inc     = 1'b1;
            start_clear = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         smp_e       <= 1'b0;
         smp_rs      <= 1'b0;
         smp_rw      <= 1'b0;
         smp_db      <= 4'h0;
         e_prev      <= 1'b0;
         state       <= CLEARING;
         fill_idx    <= 7'h00;
         cnt         <= '0;
         busy        <= 1'b1;
         four_bit    <= 1'b0;
         two_line    <= 1'b0;
         display_on  <= 1'b0;
         cursor_on   <= 1'b0;
         blink_on    <= 1'b0;
         cursor_addr <= 7'h00;
         inc_dir     <= 1'b1;
         cgram_sel   <= 1'b0;
         phase_lo    <= 1'b0;
         hi_nib      <= 4'h0;
         cmd_valid   <= 1'b0;
         cmd_byte    <= 8'h00;
         cmd_rs      <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         smp_e  <= src_e;
         smp_rs <= src_rs;
         smp_rw <= src_rw;
         smp_db <= src_db;
         e_prev <= smp_e;

         cmd_valid <= byte_done;
         if (byte_done) begin
            cmd_byte <= byte_val;
            cmd_rs   <= smp_rs;
         end
         if ((take && busy) || addr_err)
            proto_err <= 1'b1;
         if (nib_ok && four_bit) begin
            phase_lo <= ~phase_lo;
            if (!phase_lo)
               hi_nib <= smp_db;
         end

         four_bit    <= nxt_four;
         two_line    <= nxt_two;
         display_on  <= nxt_disp;
         cursor_on   <= nxt_cur;
         blink_on    <= nxt_blink;
         cursor_addr <= nxt_ac;
         inc_dir     <= nxt_inc;
         cgram_sel   <= nxt_cg;

         // The busy counter keeps running while CLEARING, so a clear's
         // fill overlaps its long busy window.
         case (state)
            IDLE: begin
               if (byte_done) begin
                  busy <= 1'b1;
                  if (start_clear) begin
                     state    <= CLEARING;
                     fill_idx <= 7'h00;
                     cnt      <= CNT_LONG;
                  end else begin
                     state <= BUSY;
                     cnt   <= use_long ? CNT_LONG : CNT_SHORT;
                  end
               end
            end
            CLEARING: begin
               fill_idx <= fill_idx + 7'd1;
               if (fill_idx == 7'(DDRAM_DEPTH - 1)) begin
                  if (cnt == '0) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     cnt   <= cnt - 1'b1;
                     state <= BUSY;
                  end
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   logic [7:0] wr_rdata_unused;

   lcd_hd44780_rx_ddram u_ddram (
      .clk      (clk),
      .rst      (rst),
      .we       (mem_we),
      .waddr    (mem_waddr),
      .wdata    (mem_wdata),
      .wr_rdata (wr_rdata_unused),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_hd44780_rx : scoreboard bench for the HD44780 responder.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lcd_hd44780_rx;

   localparam int BS = 20;
   localparam int BL = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] rd_addr = 7'h00;
   logic [7:0] rd_data;
   logic       busy, four_bit, two_line, display_on, cursor_on, blink_on;
   logic [6:0] cursor_addr;
   logic       cmd_valid, cmd_rs, proto_err;
   logic [7:0] cmd_byte;

   always #5 clk = ~clk;

   lcd_hd44780_rx_if bus ();

   lcd_hd44780_rx #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .busy        (busy),
      .four_bit    (four_bit),
      .two_line    (two_line),
      .display_on  (display_on),
      .cursor_on   (cursor_on),
      .blink_on    (blink_on),
      .cursor_addr (cursor_addr),
      .cmd_valid   (cmd_valid),
      .cmd_byte    (cmd_byte),
      .cmd_rs      (cmd_rs),
      .proto_err   (proto_err)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [8:0] sb_q[$];
   logic [8:0] sb_exp;

   // Every accepted byte must match the oldest expected {rs, byte}.
   always @(negedge clk) begin
      if (!rst && cmd_valid) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_unexpected: got rs=%0b byte=%h, required no byte", cmd_rs, cmd_byte);
         end else begin
            sb_exp = sb_q.pop_front();
            if ({cmd_rs, cmd_byte} !== sb_exp) begin
               n_bad++;
               $display("FAIL scoreboard_byte: got %h, required %h", {cmd_rs, cmd_byte}, sb_exp);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic strobe_nib(input logic rs, input logic [3:0] d);
      bus.lcd_rs = rs;
      bus.lcd_rw = 1'b0;
      bus.lcd_db = d;
      tick(1);
      bus.lcd_e = 1'b1;
      tick(2);
      bus.lcd_e = 1'b0;
      tick(1);
   endtask

   task automatic wait_idle();
      int i;
      tick(6);
      i = 0;
      while (busy && i < 50000) begin
         tick(1);
         i++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL busy_timeout: got busy=%b, required 0", busy);
      end
   endtask

   task automatic send8(input logic rs, input logic [7:0] b);
      sb_q.push_back({rs, b});
      strobe_nib(rs, b[7:4]);
      wait_idle();
   endtask

   task automatic send4(input logic rs, input logic [7:0] b);
      sb_q.push_back({rs, b});
      strobe_nib(rs, b[7:4]);
      strobe_nib(rs, b[3:0]);
      wait_idle();
   endtask

   task automatic wait_cmd(output int len);
      int k;
      k   = 0;
      len = -1;
      @(negedge clk);
      while (!cmd_valid && k < 30) begin
         @(negedge clk);
         k++;
      end
      if (cmd_valid) begin
         len = 0;
         while (busy && len < 60000) begin
            len++;
            @(negedge clk);
         end
      end
      tick(1);
   endtask

   task automatic read_mem(input logic [6:0] a, output logic [7:0] d);
      rd_addr = a;
      @(posedge clk);
      @(negedge clk);
      d = rd_data;
      tick(0);
   endtask

   task automatic test_reset();
      int         cnt;
      logic [7:0] d;
      logic [6:0] addrs [3];
      addrs = '{7'd0, 7'd40, 7'd79};
      bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_db = 4'h0;
      rst = 1'b1;
      tick(3);
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b, required 1", busy); end
      n_cmp++;
      if ({four_bit, two_line, display_on, cursor_on, blink_on, cmd_valid, cmd_rs, proto_err} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_flags: got %b, required 00000000",
                  {four_bit, two_line, display_on, cursor_on, blink_on, cmd_valid, cmd_rs, proto_err});
      end
      n_cmp++;
      if (cursor_addr !== 7'h00) begin n_bad++; $display("FAIL reset_ac: got %h, required 00", cursor_addr); end
      n_cmp++;
      if (cmd_byte !== 8'h00) begin n_bad++; $display("FAIL reset_cmd_byte: got %h, required 00", cmd_byte); end
      n_cmp++;
      if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data: got %h, required 00", rd_data); end
      rst = 1'b0;
      cnt = 0;
      while (cnt < 200) begin
         @(negedge clk);
         if (!busy) break;
         cnt++;
      end
      n_cmp++;
      if (cnt != 80) begin n_bad++; $display("FAIL reset_clear_len: got %0d cycles, required 80", cnt); end
      tick(1);
      foreach (addrs[i]) begin
         read_mem(addrs[i], d);
         n_cmp++;
         if (d !== 8'h20) begin n_bad++; $display("FAIL reset_fill[%0d]: got %h, required 20", addrs[i], d); end
      end
   endtask

   task automatic test_init();
      int len;
      send8(1'b0, 8'h30);
      send8(1'b0, 8'h30);
      send8(1'b0, 8'h30);
      send8(1'b0, 8'h20);
      n_cmp++;
      if (four_bit !== 1'b1) begin n_bad++; $display("FAIL init_four_bit: got %b, required 1", four_bit); end
      send4(1'b0, 8'h28);
      sb_q.push_back({1'b0, 8'h0C});
      strobe_nib(1'b0, 4'h0);
      strobe_nib(1'b0, 4'hC);
      wait_cmd(len);
      n_cmp++;
      if (len != BS) begin n_bad++; $display("FAIL busy_short_len: got %0d, required %0d", len, BS); end
      n_cmp++;
      if ({display_on, cursor_on, blink_on} !== 3'b100) begin
         n_bad++; $display("FAIL init_dcb: got %b, required 100", {display_on, cursor_on, blink_on});
      end
      send4(1'b0, 8'h06);
      sb_q.push_back({1'b0, 8'h01});
      strobe_nib(1'b0, 4'h0);
      strobe_nib(1'b0, 4'h1);
      wait_cmd(len);
      n_cmp++;
      if (len != BL) begin n_bad++; $display("FAIL busy_long_len: got %0d, required %0d", len, BL); end
      n_cmp++;
      if ({four_bit, two_line, display_on} !== 3'b111) begin
         n_bad++; $display("FAIL init_flags: got %b, required 111", {four_bit, two_line, display_on});
      end
      n_cmp++;
      if (cursor_addr !== 7'h00) begin n_bad++; $display("FAIL clear_ac: got %h, required 00", cursor_addr); end
   endtask

   task automatic test_wrap_inc();
      logic [7:0] d;
      send4(1'b0, 8'hA7);
      n_cmp++;
      if (cursor_addr !== 7'h27) begin n_bad++; $display("FAIL set_ac: got %h, required 27", cursor_addr); end
      send4(1'b1, 8'h41);
      send4(1'b1, 8'h42);
      n_cmp++;
      if (cursor_addr !== 7'h41) begin n_bad++; $display("FAIL inc_wrap_ac: got %h, required 41", cursor_addr); end
      read_mem(7'd39, d);
      n_cmp++;
      if (d !== 8'h41) begin n_bad++; $display("FAIL inc_wrap_idx39: got %h, required 41", d); end
      read_mem(7'd40, d);
      n_cmp++;
      if (d !== 8'h42) begin n_bad++; $display("FAIL inc_wrap_idx40: got %h, required 42", d); end
   endtask

   task automatic test_wrap_dec();
      logic [7:0] d;
      send4(1'b0, 8'h04);
      send4(1'b0, 8'h80);
      send4(1'b1, 8'h43);
      n_cmp++;
      if (cursor_addr !== 7'h67) begin n_bad++; $display("FAIL dec_wrap_ac: got %h, required 67", cursor_addr); end
      read_mem(7'd0, d);
      n_cmp++;
      if (d !== 8'h43) begin n_bad++; $display("FAIL dec_wrap_idx0: got %h, required 43", d); end
   endtask

   task automatic test_busy_strobe();
      int len;
      n_cmp++;
      if (proto_err !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b, required 0", proto_err); end
      sb_q.push_back({1'b0, 8'h0F});
      strobe_nib(1'b0, 4'h0);
      strobe_nib(1'b0, 4'hF);
      @(negedge clk);
      len = 0;
      while (!cmd_valid && len < 30) begin
         @(negedge clk);
         len++;
      end
      tick(0);
      strobe_nib(1'b0, 4'h0);
      tick(6);
      n_cmp++;
      if (proto_err !== 1'b1) begin n_bad++; $display("FAIL busy_strobe_err: got %b, required 1", proto_err); end
      wait_idle();
      n_cmp++;
      if ({cursor_on, blink_on} !== 2'b11) begin
         n_bad++; $display("FAIL busy_dcb: got %b, required 11", {cursor_on, blink_on});
      end
      send4(1'b0, 8'h06);
   endtask

   task automatic test_reset_midbyte();
      n_cmp++;
      if (four_bit !== 1'b1) begin n_bad++; $display("FAIL midbyte_pre: got %b, required 1", four_bit); end
      strobe_nib(1'b0, 4'h4);
      tick(6);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      n_cmp++;
      if (four_bit !== 1'b0) begin n_bad++; $display("FAIL midbyte_four_bit: got %b, required 0", four_bit); end
      wait_idle();
      send8(1'b0, 8'h30);
      n_cmp++;
      if (four_bit !== 1'b0) begin n_bad++; $display("FAIL midbyte_after: got %b, required 0", four_bit); end
   endtask

   task automatic test_invalid_addr();
      send8(1'b0, 8'h90);
      n_cmp++;
      if ({proto_err, cursor_addr} !== {1'b0, 7'h10}) begin
         n_bad++; $display("FAIL valid_addr: got err=%b ac=%h, required err=0 ac=10", proto_err, cursor_addr);
      end
      send8(1'b0, 8'hD0);
      n_cmp++;
      if ({proto_err, cursor_addr} !== {1'b1, 7'h00}) begin
         n_bad++; $display("FAIL invalid_addr: got err=%b ac=%h, required err=1 ac=00", proto_err, cursor_addr);
      end
   endtask

   initial begin
      bus.lcd_e  = 1'b0;
      bus.lcd_rs = 1'b0;
      bus.lcd_rw = 1'b0;
      bus.lcd_db = 4'h0;
      test_reset();
      test_init();
      test_wrap_inc();
      test_wrap_dec();
      test_busy_strobe();
      test_reset_midbyte();
      test_invalid_addr();
      tick(4);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lcd_hd44780_rx.md
# lcd_hd44780_rx

HD44780-compatible display responder: the LCD-side endpoint of the 4-bit parallel bus driven by the LCD host/init logic. It samples E/RS/RW/DB7..DB4, assembles nibbles into bytes, decodes the instruction set, maintains an 80-byte DDRAM and the display flags, and models the busy period. It serves as a synthesizable bus-functional target for host-side verification and as a source for mirroring LCD contents onto the video path.

## Interface
- BUSY_SHORT, 1000: busy cycles after a normal instruction or data write (40 µs at 25 MHz).
- BUSY_LONG, 41000: busy cycles after clear/return-home (1.64 ms); must be ≥ 80.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- lcd_e  in  1  enable strobe; data is latched on its falling edge.
- lcd_rs  in  1  0 = instruction, 1 = data.
- lcd_rw  in  1  1 = read strobe (ignored).
- lcd_db  in  4  DB7..DB4.
- rd_addr  in  7  DDRAM index, 0..79, for the mirror port.
- rd_data  out  8  DDRAM[rd_addr], registered.
- busy  out  1  instruction in progress.
- four_bit  out  1  interface width flag (DL=0).
- two_line  out  1  N flag.
- display_on / cursor_on / blink_on  out  1 each  D/C/B flags.
- cursor_addr  out  7  HD44780 address counter (AC).
- cmd_valid  out  1  one-cycle pulse per accepted byte.
- cmd_byte  out  8  accepted byte.
- cmd_rs  out  1  RS of the accepted byte.
- proto_err  out  1  sticky; cleared only by rst.

## Operation
- Strobe is a detected E 1→0 transition on the sampled inputs. RS, RW and DB are taken from the same sample.
- Strobes with RW=1 are ignored entirely: no phase change and no error.
- **8-bit mode** (the reset state): each strobe forms byte {DB, 4'h0}.
- **4-bit mode**: the first strobe is the high nibble and the second is the low nibble. The byte completes on the low nibble.
- **Strobe while busy=1**: discarded, proto_err set, nibble phase unchanged.
- **Instruction decode**, highest set bit wins:
  - 0x01 clear: fill DDRAM with 0x20, AC=0, I/D=1, BUSY_LONG.
  - 0x02/0x03 home: AC=0, BUSY_LONG.
  - 0x04–07 entry mode: I/D = bit1. The shift bit is ignored.
  - 0x08–0F: D = bit2, C = bit1, B = bit0.
  - 0x10–1F: if S/C=0, move AC per R/L (bit2). Display shift is ignored.
  - 0x20–3F function set: DL = bit4, N = bit3. Switching to 4-bit resets the phase to high nibble.
  - 0x40–7F CGRAM address: sets cgram_sel. Subsequent data writes are discarded until the next DDRAM address set.
  - 0x80–FF: AC = bits[6:0], clears cgram_sel.
- **Data (RS=1)**: write DDRAM[index(AC)], then step AC by ±1.
- **Indexing**:
  - 1-line mode: index = AC, range 0..79, wraps 79↔0.
  - 2-line mode: index = line·40 + col. Valid AC is 0x00–0x27 and 0x40–0x67. Increment wraps 0x27→0x40 and 0x67→0x00; decrement does the reverse.
- **Invalid DDRAM address set** (col ≥ 40 in 2-line mode, ≥ 80 in 1-line mode): AC=0, proto_err set.

## Timing
- **Reset values**:
  - busy=1.
  - four_bit, two_line, display_on, cursor_on, blink_on, cmd_valid, cmd_rs, proto_err, cgram_sel = 0.
  - cmd_byte=0, AC=0, I/D=1, phase=high, rd_data=0.
- **Reset clear**: reset launches an 80-cycle DDRAM clear to 0x20. busy falls on the cycle after the last write.
- **Byte completion**: one clk after the strobe-detect cycle, cmd_valid, cmd_byte, cmd_rs, busy, the flags, AC and the DDRAM write all update together.
- **Busy duration**: busy stays high for exactly BUSY_SHORT cycles (or BUSY_LONG), counted from the cmd_valid cycle. Clear-fill runs concurrently within BUSY_LONG.
- **Mirror read**: rd_data has 1-cycle latency. A read and write to the same index in the same cycle returns the old data.
- **rst mid-byte**: a pending high nibble is lost and the block returns to 8-bit mode.

## Configuration
- LCD_RX_SYNC_EN defined: lcd_e, lcd_rs, lcd_rw and lcd_db each pass through a 2-flop synchronizer before edge detect. This adds 2 cycles of latency and allows an asynchronous/off-chip host.
- Not defined: inputs are registered once (single flop) for edge detect. The host must be in the clk domain.

## Structure
- lcd_pkg holds:
  - instruction opcode masks;
  - DDRAM_DEPTH=80, LINE_LEN=40, LINE2_BASE=7'h40, CHAR_SPACE=8'h20;
  - the control FSM state encoding: IDLE, CLEARING, BUSY.
- Sub-module lcd_ddram: 80×8 memory with a single write port and two read ports (the write-port read is unused), registered reads, no reset.

## Test plan
- **Reset**: assert rst → busy=1 for 80 cycles then 0; reading rd_addr 0, 40 and 79 returns 0x20.
- **Init sequence**: nibble sequence 3,3,3,2,2,8,0,C,0,6,0,1 with waits → cmd_byte sequence 0x30,0x30,0x30,0x20,0x28,0x0C,0x06,0x01. Then four_bit=1, two_line=1, display_on=1, and busy stays high for BUSY_LONG after 0x01.
- **2-line wrap on increment**: 2-line mode, instruction 0xA7, data 'A' then 'B' → index 39=0x41, index 40=0x42, cursor_addr=0x41.
- **2-line wrap on decrement**: entry mode 0x04, AC=0x00, one data write → index 0 written, cursor_addr=0x67.
- **Strobe during busy**: strobe while busy=1 → no cmd_valid, proto_err=1, and the next two nibbles after busy falls form one correct byte.
- **Reset mid-byte**: in 4-bit mode, send the high nibble 0x4, then pulse rst → four_bit=0, and the next strobe with DB=0x3 yields cmd_byte=0x30.
